button_debouncer: RTL and testbench

- Debounces and conditions the raw active-low organ key inputs before they gate the note sources.
- Produces clean active-high per-key enables, one-cycle press/release strobes and an any-key flag.
- Sits directly upstream of the organ voice/mixing logic, replacing the bare inversion of the raw button inputs.
- Optional toggle mode latches a note on or off on alternate presses (sustain).

---
 rtl/button_debouncer.sv | 191 +++++++++++++++++++
 tb/tb_button_debouncer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Organ key conditioner: synchronise, debounce and edge-detect the raw
// active-low keys, with an optional per-key sustain toggle.
module button_debouncer #(
  parameter int BUTTONS      = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 5,
  parameter bit TOGGLE       = 1'b0
) (
  input  logic               oneMHzClock,
  input  logic               reset_n,
  input  logic [1:BUTTONS]   button_n,
  output logic [1:BUTTONS]   noteButton,
  output logic [1:BUTTONS]   press_pulse,
  output logic [1:BUTTONS]   release_pulse,
  output logic               any_held
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CLAST = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_e;

  logic [1:BUTTONS] sync1_q;
  logic [1:BUTTONS] sync2_q;
  logic [1:BUTTONS] p;

  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic             tick;

  state_e           state_q [1:BUTTONS];
  state_e           state_d [1:BUTTONS];
  logic [CW-1:0]    cnt_q   [1:BUTTONS];
  logic [CW-1:0]    cnt_d   [1:BUTTONS];

  logic [1:BUTTONS] press_q;
  logic [1:BUTTONS] press_d;
  logic [1:BUTTONS] release_q;
  logic [1:BUTTONS] release_d;
  logic [1:BUTTONS] note_q;
  logic [1:BUTTONS] note_d;
  logic [1:BUTTONS] held_d;
  logic             any_q;
  logic             any_d;

  // Two-flop synchroniser; idles at 1 so reset looks like "released".
  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= button_n;
      sync2_q <= sync1_q;
    end
  end

  assign p = ~sync2_q;

  assign tick = (presc_q == PMAX);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // FSM: state register
  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i <= BUTTONS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 1; i <= BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // FSM: next state; a disagreeing sample always beats a tick
  always_comb begin
    for (int i = 1; i <= BUTTONS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (p[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!p[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CLAST) begin
              state_d[i] = HELD;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        HELD: begin
          if (!p[i]) begin
            state_d[i] = REL_CHK;
            cnt_d[i]   = '0;
          end
        end
        REL_CHK: begin
          if (p[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CLAST) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // FSM: outputs, computed from the transition and registered below
  always_comb begin
    press_d   = '0;
    release_d = '0;
    held_d    = '0;
    note_d    = note_q;
    for (int i = 1; i <= BUTTONS; i++) begin
      press_d[i]   = (state_q[i] == PRESS_CHK) &&
                     (state_d[i] == HELD);
      release_d[i] = (state_q[i] == REL_CHK) &&
                     (state_d[i] == IDLE);
      held_d[i]    = (state_d[i] == HELD) ||
                     (state_d[i] == REL_CHK);
      if (TOGGLE) begin
        note_d[i] = note_q[i] ^ press_d[i];
      end else begin
        note_d[i] = held_d[i];
      end
    end
    any_d = |held_d;
  end

  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      press_q   <= '0;
      release_q <= '0;
      note_q    <= '0;
      any_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      note_q    <= note_d;
      any_q     <= any_d;
    end
  end

  assign noteButton    = note_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_held      = any_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: one follow-mode and
// one toggle-mode instance at TICK_DIV=4, STABLE_TICKS=3.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:4] button_n = 4'b1111;
  logic [1:4] noteButton;
  logic [1:4] press_pulse;
  logic [1:4] release_pulse;
  logic       any_held;

  logic [1:4] button_t_n = 4'b1111;
  logic [1:4] note_t;
  logic [1:4] press_t;
  logic [1:4] release_t;
  logic       any_t;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int pcnt [1:4];
  int rcnt [1:4];
  int tpcnt [1:4];
  int trcnt [1:4];
  logic [1:4] prev_pulse = '0;

  always #5 clk = ~clk;

  button_debouncer #(
    .BUTTONS(4), .TICK_DIV(4), .STABLE_TICKS(3), .TOGGLE(1'b0)
  ) dut (
    .oneMHzClock  (clk),
    .reset_n      (reset_n),
    .button_n     (button_n),
    .noteButton   (noteButton),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_held     (any_held)
  );

  button_debouncer #(
    .BUTTONS(4), .TICK_DIV(4), .STABLE_TICKS(3), .TOGGLE(1'b1)
  ) dut_t (
    .oneMHzClock  (clk),
    .reset_n      (reset_n),
    .button_n     (button_t_n),
    .noteButton   (note_t),
    .press_pulse  (press_t),
    .release_pulse(release_t),
    .any_held     (any_t)
  );

  initial begin
    for (int k = 1; k <= 4; k++) begin
      pcnt[k] = 0; rcnt[k] = 0; tpcnt[k] = 0; trcnt[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 1; k <= 4; k++) begin
      if (press_pulse[k])   pcnt[k]++;
      if (release_pulse[k]) rcnt[k]++;
      if (press_t[k])       tpcnt[k]++;
      if (release_t[k])     trcnt[k]++;
    end
    if (|(press_pulse & release_pulse)) viol++;
    if (|((press_pulse | release_pulse) & prev_pulse)) viol++;
    prev_pulse = press_pulse | release_pulse;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int n,
                         input int lo, input int hi);
    checks++;
    assert (n >= lo && n <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, n, lo, hi);
    end
  endtask

  // kind: 0 press, 1 release (follow dut); 2 press, 3 release (toggle dut)
  task automatic wait_pulse(input int kind, input int key, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      step();
      n++;
      if (kind == 0)      hit = press_pulse[key];
      else if (kind == 1) hit = release_pulse[key];
      else if (kind == 2) hit = press_t[key];
      else                hit = release_t[key];
    end
  endtask

  int n;
  int base;
  int base2;

  initial begin
    button_n = 4'b0000;
    repeat (3) step();
    chk("rst_note", 32'(noteButton), 32'h0);
    chk("rst_press", 32'(press_pulse), 32'h0);
    chk("rst_release", 32'(release_pulse), 32'h0);
    chk("rst_any", 32'(any_held), 32'h0);

    reset_n = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      chk("prequal_note", 32'(noteButton), 32'h0);
    end
    step();
    chk("postrst_press", 32'(press_pulse), 32'hF);
    chk("postrst_note", 32'(noteButton), 32'hF);
    chk("postrst_any", 32'(any_held), 32'h1);
    step();
    chk("postrst_press_1cyc", 32'(press_pulse), 32'h0);
    button_n = 4'b1111;
    wait_pulse(1, 1, n);
    chk_rng("postrst_rel_win", n, 11, 15);
    chk("postrst_rel", 32'(release_pulse), 32'hF);
    chk("postrst_rel_note", 32'(noteButton), 32'h0);
    chk("postrst_rel_any", 32'(any_held), 32'h0);
    repeat (5) step();

    button_n[2] = 1'b0;
    wait_pulse(0, 2, n);
    chk_rng("k2_press_win", n, 11, 15);
    chk("k2_press", 32'(press_pulse), 32'(4'b0100));
    chk("k2_note", 32'(noteButton), 32'(4'b0100));
    step();
    chk("k2_press_1cyc", 32'(press_pulse), 32'h0);
    repeat (3) step();
    button_n[2] = 1'b1;
    wait_pulse(1, 2, n);
    chk_rng("k2_rel_win", n, 11, 15);
    chk("k2_rel", 32'(release_pulse), 32'(4'b0100));
    chk("k2_rel_note", 32'(noteButton), 32'h0);
    repeat (5) step();

    base = pcnt[1];
    for (int s = 0; s < 10; s++) begin
      button_n[1] = s[0];
      repeat (3) step();
    end
    chk("k1_bounce_nopulse", 32'(pcnt[1] - base), 32'h0);
    chk("k1_bounce_note", 32'(noteButton), 32'h0);
    button_n[1] = 1'b0;
    wait_pulse(0, 1, n);
    chk_rng("k1_press_win", n, 11, 15);
    repeat (20) step();
    chk("k1_one_press", 32'(pcnt[1] - base), 32'h1);
    chk("k1_note", 32'(noteButton), 32'(4'b1000));
    button_n[1] = 1'b1;
    wait_pulse(1, 1, n);
    chk_rng("k1_rel_win", n, 11, 15);
    repeat (5) step();

    button_n[3] = 1'b0;
    wait_pulse(0, 3, n);
    chk_rng("k3_press_win", n, 11, 15);
    repeat (5) step();
    base = rcnt[3];
    button_n[3] = 1'b1;
    repeat (2) step();
    button_n[3] = 1'b0;
    repeat (25) step();
    chk("k3_glitch_norel", 32'(rcnt[3] - base), 32'h0);
    chk("k3_glitch_note", 32'(noteButton), 32'(4'b0010));
    button_n[3] = 1'b1;
    wait_pulse(1, 3, n);
    chk_rng("k3_rel_win", n, 11, 15);
    repeat (5) step();

    base = tpcnt[4];
    base2 = trcnt[4];
    button_t_n[4] = 1'b0;
    wait_pulse(2, 4, n);
    chk("t4_note_1", 32'(note_t[4]), 32'h1);
    repeat (3) step();
    button_t_n[4] = 1'b1;
    wait_pulse(3, 4, n);
    step();
    chk("t4_note_2", 32'(note_t[4]), 32'h1);
    repeat (3) step();
    button_t_n[4] = 1'b0;
    wait_pulse(2, 4, n);
    chk("t4_note_3", 32'(note_t[4]), 32'h0);
    repeat (3) step();
    button_t_n[4] = 1'b1;
    wait_pulse(3, 4, n);
    step();
    chk("t4_note_4", 32'(note_t[4]), 32'h0);
    repeat (3) step();
    chk("t4_presses", 32'(tpcnt[4] - base), 32'h2);
    chk("t4_releases", 32'(trcnt[4] - base2), 32'h2);

    button_n = 4'b0110;
    wait_pulse(0, 1, n);
    chk_rng("k14_press_win", n, 11, 15);
    chk("k14_press", 32'(press_pulse), 32'(4'b1001));
    chk("k14_note", 32'(noteButton), 32'(4'b1001));
    chk("k14_any", 32'(any_held), 32'h1);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("async_rst_note", 32'(noteButton), 32'h0);
    chk("async_rst_any", 32'(any_held), 32'h0);
    chk("async_rst_press", 32'(press_pulse), 32'h0);
    button_n = 4'b1111;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (20) step();
    chk("post_rst_quiet", 32'(noteButton), 32'h0);
    chk("pulse_rules", 32'(viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
